// File: rtl/sr_dmem_port_if.sv
// sr_dmem_port bus interface: req/gnt/rvalid link toward the memory interconnect.
interface sr_dmem_port_if #(
  parameter int ADDR_W = 16
) ();
  logic              busReq;
  logic              busWe;
  logic [ADDR_W-1:0] busAddr;
  logic [31:0]       busWdata;
  logic              busGnt;
  logic              busRvalid;
  logic [31:0]       busRdata;

  modport master (
    output busReq, busWe, busAddr, busWdata,
    input  busGnt, busRvalid, busRdata
  );

  modport slave (
    input  busReq, busWe, busAddr, busWdata,
    output busGnt, busRvalid, busRdata
  );
endinterface

// File: rtl/sr_dmem_port.sv
// sr_cpu data-memory port: store buffer, load FSM, shared bus master.
// Define SR_DMEM_SB_FORWARD_EN to serve loads from buffered stores.
module sr_dmem_port #(
  parameter int SB_DEPTH = 4,
  parameter int ADDR_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [2:0]            memInstr,
  input  logic [31:0]           memAddress,
  input  logic [31:0]           memData,
  output logic [31:0]           dataToCpu,
  output logic                  dataSent,
  output logic                  sbFull,
  sr_dmem_port_if.master        bus
);
  localparam int PW = $clog2(SB_DEPTH);
  localparam logic [2:0] AGU_LOAD  = 3'd1;
  localparam logic [2:0] AGU_STORE = 3'd2;

  typedef enum logic [2:0] {
    S_IDLE, S_DRAIN, S_LD_REQ, S_LD_WAIT, S_LD_RESP
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] sb_addr_q [SB_DEPTH];
  logic [31:0]       sb_data_q [SB_DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q, nxt_idx;
  logic [PW:0]       cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d, last_q;
  logic [31:0]       wdata_q, wdata_d, rdata_q, rdata_d;
  logic              skip_q;
  logic [ADDR_W-1:0] ld_waddr;
  logic              push, pop, ld_pend, sb_empty, last_one;
  logic              unused_addr_bits;

  assign ld_waddr = memAddress[ADDR_W+1:2];
  assign unused_addr_bits = ^{memAddress[31:ADDR_W+2], memAddress[1:0]};
  assign sbFull   = cnt_q == (PW+1)'(SB_DEPTH);
  assign sb_empty = cnt_q == '0;
  assign push     = (memInstr == AGU_STORE) && !sbFull;
  assign pop      = (state_q == S_DRAIN) && bus.busGnt;
  assign last_one = (cnt_q == (PW+1)'(1)) && !push;
  assign nxt_idx  = rd_ptr_q + PW'(1);

  // the just-completed load may still be shown for one cycle
  assign ld_pend = (memInstr == AGU_LOAD) &&
                   !(skip_q && ld_waddr == last_q);

`ifdef SR_DMEM_SB_FORWARD_EN
  logic          fwd_hit;
  logic [31:0]   fwd_data;
  logic [PW-1:0] fwd_idx;

  // oldest to youngest, so the last match wins
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      fwd_idx = rd_ptr_q + PW'(i);
      if ((PW+1)'(i) < cnt_q &&
          sb_addr_q[fwd_idx] == ld_waddr) begin
        fwd_hit  = 1'b1;
        fwd_data = sb_data_q[fwd_idx];
      end
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    unique case (state_q)
      S_IDLE: begin
`ifdef SR_DMEM_SB_FORWARD_EN
        if (ld_pend && fwd_hit) begin
          state_d = S_LD_RESP;
          rdata_d = fwd_data;
        end else if (ld_pend) begin
          state_d = S_LD_REQ;
          addr_d  = ld_waddr;
        end else if (!sb_empty) begin
`else
        if (ld_pend && sb_empty) begin
          state_d = S_LD_REQ;
          addr_d  = ld_waddr;
        end else if (!sb_empty) begin
`endif
          state_d = S_DRAIN;
          addr_d  = sb_addr_q[rd_ptr_q];
          wdata_d = sb_data_q[rd_ptr_q];
        end
      end
      S_DRAIN: begin
        if (bus.busGnt) begin
          if (last_one) begin
            state_d = ld_pend ? S_LD_REQ : S_IDLE;
            addr_d  = ld_pend ? ld_waddr : addr_q;
          end else if (push && wr_ptr_q == nxt_idx) begin
            addr_d  = ld_waddr;
            wdata_d = memData;
          end else begin
            addr_d  = sb_addr_q[nxt_idx];
            wdata_d = sb_data_q[nxt_idx];
          end
        end
      end
      S_LD_REQ: begin
        if (bus.busGnt) state_d = S_LD_WAIT;
      end
      S_LD_WAIT: begin
        if (bus.busRvalid) begin
          state_d = S_LD_RESP;
          rdata_d = bus.busRdata;
        end
      end
      S_LD_RESP: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      last_q   <= '0;
      skip_q   <= 1'b0;
      for (int i = 0; i < SB_DEPTH; i++) begin
        sb_addr_q[i] <= '0;
        sb_data_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      skip_q  <= state_q == S_LD_RESP;
      if (state_q == S_LD_RESP) last_q <= ld_waddr;
      if (push) begin
        sb_addr_q[wr_ptr_q] <= ld_waddr;
        sb_data_q[wr_ptr_q] <= memData;
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  assign bus.busReq   = (state_q == S_DRAIN) || (state_q == S_LD_REQ);
  assign bus.busWe    = state_q == S_DRAIN;
  assign bus.busAddr  = addr_q;
  assign bus.busWdata = wdata_q;
  assign dataSent     = state_q == S_LD_RESP;
  assign dataToCpu    = rdata_q;
endmodule

// File: tb/tb_sr_dmem_port.sv
// Directed bench for sr_dmem_port with a small bus responder.
module tb_sr_dmem_port;
  localparam logic [2:0] OP_IDLE  = 3'd0;
  localparam logic [2:0] OP_LOAD  = 3'd1;
  localparam logic [2:0] OP_STORE = 3'd2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  memInstr;
  logic [31:0] memAddress, memData, dataToCpu;
  logic        dataSent, sbFull;

  sr_dmem_port_if #(.ADDR_W(16)) bus ();

  sr_dmem_port #(.SB_DEPTH(4), .ADDR_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .memInstr   (memInstr),
    .memAddress (memAddress),
    .memData    (memData),
    .dataToCpu  (dataToCpu),
    .dataSent   (dataSent),
    .sbFull     (sbFull),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // responder / monitor state
  int          gnt_mode = 0;
  bit          hold_rv = 0;
  bit          force_rv = 0;
  int          rd_tok = 0;
  logic [31:0] rd_data = '0;
  logic [31:0] mem [int];
  int          n_rd = 0, n_wr = 0, ev = 0, wr_ev = 0, rd_ev = 0;
  logic [15:0] wa [64];
  logic [31:0] wd [64];

  always @(negedge clk) begin
    if (rst_n && bus.busReq && bus.busGnt) begin
      ev++;
      if (bus.busWe) begin
        if (n_wr < 64) begin
          wa[n_wr] = bus.busAddr;
          wd[n_wr] = bus.busWdata;
        end
        mem[int'(bus.busAddr)] = bus.busWdata;
        n_wr++;
        wr_ev = ev;
      end else begin
        rd_data = mem.exists(int'(bus.busAddr)) ?
                  mem[int'(bus.busAddr)] : 32'hDEADBEEF;
        n_rd++;
        rd_ev = ev;
        rd_tok++;
      end
    end
  end

  initial begin
    int rd_seen;
    rd_seen = 0;
    bus.busGnt = 1'b0;
    bus.busRvalid = 1'b0;
    bus.busRdata = '0;
    forever begin
      @(posedge clk);
      #2;
      case (gnt_mode)
        1:       bus.busGnt = 1'b1;
        2:       bus.busGnt = 1'($urandom_range(0, 1));
        default: bus.busGnt = 1'b0;
      endcase
      bus.busRvalid = 1'b0;
      if (force_rv) begin
        bus.busRvalid = 1'b1;
        bus.busRdata  = 32'hCAFE0000;
      end else if (rd_tok != rd_seen && !hold_rv) begin
        bus.busRvalid = 1'b1;
        bus.busRdata  = rd_data;
      end
      rd_seen = rd_tok;
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic wait_sent(input int max, output int k);
    k = 0;
    smp();
    while (!dataSent && k < max) begin
      nxt();
      smp();
      k++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int b_rd, b_wr, k, stable, i, tmo;
    bit sent_seen;
    memInstr = OP_IDLE;
    memAddress = '0;
    memData = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    smp();
    check("rst_dataToCpu", dataToCpu, 32'h0);
    check("rst_dataSent", 32'(dataSent), 32'h0);
    check("rst_busReq", 32'(bus.busReq), 32'h0);
    check("rst_busWe", 32'(bus.busWe), 32'h0);
    check("rst_busAddr", 32'(bus.busAddr), 32'h0);
    check("rst_busWdata", bus.busWdata, 32'h0);
    check("rst_sbFull", 32'(sbFull), 32'h0);

    // load, empty buffer: dataSent on cycle 3
    nxt();
    gnt_mode = 1;
    b_rd = n_rd;
    memInstr = OP_LOAD;
    memAddress = 32'h40;
    smp();
    check("ld_c0_req", 32'(bus.busReq), 32'h0);
    nxt(); smp();
    check("ld_c1_req", 32'(bus.busReq), 32'h1);
    check("ld_c1_addr", 32'(bus.busAddr), 32'h10);
    check("ld_c1_we", 32'(bus.busWe), 32'h0);
    nxt(); smp();
    check("ld_c2_sent", 32'(dataSent), 32'h0);
    nxt(); smp();
    check("ld_c3_sent", 32'(dataSent), 32'h1);
    check("ld_c3_data", dataToCpu, 32'hDEADBEEF);
    nxt(); smp();
    check("ld_c4_sent", 32'(dataSent), 32'h0);
    nxt();
    memInstr = OP_IDLE;
    repeat (4) nxt();
    check("ld_reads", 32'(n_rd - b_rd), 32'h1);
    check("ld_hold", dataToCpu, 32'hDEADBEEF);

    // store burst with bus stalled
    gnt_mode = 0;
    b_wr = n_wr;
    for (int j = 0; j < 4; j++) begin
      memInstr = OP_STORE;
      memAddress = 32'(4 * j);
      memData = 32'(j + 1);
      nxt();
    end
    memAddress = 32'h10;
    memData = 32'h5;
    smp();
    check("sb_full_4", 32'(sbFull), 32'h1);
    nxt();
    memInstr = OP_IDLE;
    gnt_mode = 1;
    smp();
    check("sb_full_pre_pop", 32'(sbFull), 32'h1);
    nxt(); smp();
    check("sb_full_post_pop", 32'(sbFull), 32'h0);
    tmo = 0;
    while (n_wr - b_wr < 4 && tmo < 20) begin
      nxt();
      tmo++;
    end
    repeat (4) nxt();
    check("sb_wr_count", 32'(n_wr - b_wr), 32'h4);
    for (int j = 0; j < 4; j++) begin
      check($sformatf("sb_wa%0d", j), 32'(wa[b_wr + j]), 32'(j));
      check($sformatf("sb_wd%0d", j), wd[b_wr + j], 32'(j + 1));
    end

    // load behind a store to the same word
    b_rd = n_rd;
    b_wr = n_wr;
    memInstr = OP_STORE;
    memAddress = 32'h20;
    memData = 32'h55;
    nxt();
    memInstr = OP_LOAD;
    memAddress = 32'h20;
    wait_sent(20, k);
`ifdef SR_DMEM_SB_FORWARD_EN
    check("raw_latency", 32'(k), 32'd1);
`else
    check("raw_latency", 32'(k), 32'd4);
`endif
    check("raw_data", dataToCpu, 32'h55);
    nxt();
    memInstr = OP_IDLE;
    repeat (6) nxt();
    check("raw_writes", 32'(n_wr - b_wr), 32'h1);
`ifdef SR_DMEM_SB_FORWARD_EN
    check("raw_reads", 32'(n_rd - b_rd), 32'h0);
`else
    check("raw_reads", 32'(n_rd - b_rd), 32'h1);
    check("raw_order", 32'(wr_ev < rd_ev), 32'h1);
`endif

    // grant backpressure
    gnt_mode = 0;
    b_rd = n_rd;
    memInstr = OP_LOAD;
    memAddress = 32'h80;
    stable = 0;
    for (int j = 0; j < 5; j++) begin
      nxt(); smp();
      if (bus.busReq === 1'b1 && bus.busWe === 1'b0 &&
          bus.busAddr === 16'h20)
        stable++;
    end
    check("bp_stable", 32'(stable), 32'd5);
    nxt();
    gnt_mode = 1;
    wait_sent(20, k);
    check("bp_sent", 32'(dataSent), 32'h1);
    check("bp_data", dataToCpu, 32'hDEADBEEF);
    nxt();
    memInstr = OP_IDLE;
    repeat (3) nxt();
    check("bp_reads", 32'(n_rd - b_rd), 32'h1);

    // reset while waiting for read data
    hold_rv = 1;
    memInstr = OP_LOAD;
    memAddress = 32'h40;
    nxt();
    nxt();
    rst_n = 1'b0;
    memInstr = OP_IDLE;
    nxt();
    rst_n = 1'b1;
    hold_rv = 0;
    sent_seen = 0;
    nxt();
    force_rv = 1;
    smp();
    if (dataSent) sent_seen = 1;
    nxt();
    force_rv = 0;
    for (int j = 0; j < 3; j++) begin
      smp();
      if (dataSent) sent_seen = 1;
      nxt();
    end
    check("rst_mid_sent", 32'(sent_seen), 32'h0);
    check("rst_mid_data", dataToCpu, 32'h0);
    check("rst_mid_req", 32'(bus.busReq), 32'h0);
    check("rst_mid_full", 32'(sbFull), 32'h0);

    // pointer wrap with random grants
    gnt_mode = 2;
    b_wr = n_wr;
    i = 0;
    tmo = 0;
    while (i < 10 && tmo < 200) begin
      if (!sbFull) begin
        memInstr = OP_STORE;
        memAddress = 32'h100 + 32'(4 * i);
        memData = 32'hA0 + 32'(i);
        i++;
      end else begin
        memInstr = OP_IDLE;
      end
      nxt();
      tmo++;
    end
    memInstr = OP_IDLE;
    tmo = 0;
    while (n_wr - b_wr < 10 && tmo < 200) begin
      nxt();
      tmo++;
    end
    repeat (4) nxt();
    check("wrap_count", 32'(n_wr - b_wr), 32'd10);
    for (int j = 0; j < 10; j++) begin
      check($sformatf("wrap_wa%0d", j), 32'(wa[b_wr + j]), 32'h40 + 32'(j));
      check($sformatf("wrap_wd%0d", j), wd[b_wr + j], 32'hA0 + 32'(j));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sr_dmem_port.md
Name: sr_dmem_port

Overview:
- Data-memory port of each sr_cpu core; sits directly downstream of the CPU's address-generation stage.
- Consumes the decoded memory operation (op code, byte address, store data) and returns load data with a one-cycle acknowledge pulse.
- Drives a shared req/gnt/rvalid bus toward the multicore memory interconnect.
- Buffers stores in a small FIFO so stores retire in one cycle. Loads stall the core until their data returns.

Parameters:
- SB_DEPTH, 4, store-buffer entries (power of 2, >=2)
- ADDR_W, 16, bus word-address width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- memInstr  in  3  operation, decoded with the shared AGU_IDLE/AGU_LOAD/AGU_STORE codes; any other value = idle
- memAddress  in  32  byte address; bits [1:0] ignored
- memData  in  32  store data
- dataToCpu  out  32  load result
- dataSent  out  1  one-cycle pulse: dataToCpu valid, load complete
- sbFull  out  1  store buffer full; core gates store retirement with it
- busReq  out  1  bus request
- busWe  out  1  1 = write, 0 = read
- busAddr  out  ADDR_W  word address = memAddress[ADDR_W+1:2]
- busWdata  out  32  write data
- busGnt  in  1  bus accepted request this cycle
- busRvalid  in  1  read data valid
- busRdata  in  32  read data

Behaviour:
- Reset (asynchronous, active-low, all state):
  - Outputs: dataToCpu=0, dataSent=0, busReq=0, busWe=0, busAddr=0, busWdata=0.
  - Store buffer emptied (sbFull=0). FSM enters IDLE.
  - A busRvalid arriving after reset is ignored.
- Store enqueue:
  - Condition: every cycle with memInstr==STORE and !sbFull.
  - Pushes {busAddr, memData}.
  - STORE while full is dropped; the core must stall on sbFull.
- sbFull is combinational from the registered count: count==SB_DEPTH.
- A push and a pop in the same cycle are legal; count is unchanged.
- FSM states: IDLE, DRAIN, LD_REQ, LD_WAIT, LD_RESP.
- IDLE:
  - Load pending and buffer must drain (see Optional Feature) -> DRAIN.
  - Load pending, buffer empty -> LD_REQ.
  - No load, buffer non-empty -> DRAIN.
  - Loads have priority once the buffer is empty.
- DRAIN:
  - busReq=1, busWe=1; addr/data taken from the FIFO head, registered.
  - On busGnt: pop the head.
  - Buffer becomes empty after the pop: load pending -> LD_REQ, else IDLE.
  - Otherwise stay in DRAIN and present the next entry the following cycle.
- LD_REQ:
  - busReq=1, busWe=0, busAddr from memAddress.
  - Hold until busGnt, then -> LD_WAIT.
  - Request fields must stay stable while busReq=1 and !busGnt.
- LD_WAIT:
  - busReq=0.
  - On busRvalid: capture busRdata into dataToCpu, -> LD_RESP.
  - busRvalid in any other state is ignored.
- LD_RESP:
  - dataSent=1 for exactly this cycle, -> IDLE.
  - The load is issued once even though memInstr stays LOAD until dataSent.
  - IDLE ignores memInstr in the cycle after LD_RESP only if it still shows the same load (the core advances that edge, so a new op is valid from the next cycle).
- dataToCpu holds its value until the next load capture.
- Latency: empty buffer, busGnt immediate, busRvalid one cycle after grant -> load seen cycle 0, busReq cycle 1, busRvalid cycle 2, dataSent cycle 3.
- FIFO pointers are log2(SB_DEPTH) bits with natural wrap; count is log2(SB_DEPTH)+1 bits.
- Ordering: stores reach the bus in program order. A load never returns stale data for a word written by an earlier buffered store.

Optional Feature:
- Macro: SR_DMEM_SB_FORWARD_EN
- Defined:
  - A load whose word address matches a buffered entry is served from the youngest matching entry.
  - IDLE -> LD_RESP directly, with dataToCpu loaded from that entry; dataSent on cycle 1; no bus traffic.
  - A load with no match issues to the bus immediately, bypassing buffered stores.
- Undefined:
  - Every load first drains the buffer to empty, then issues.
  - No address comparators are built.

Test Plan:
- Load, empty buffer: memInstr=LOAD, memAddress=0x40, busGnt=1, busRvalid the cycle after grant with busRdata=0xDEADBEEF -> busAddr=0x10, busWe=0, one bus read, dataSent pulses once at cycle 3, dataToCpu=0xDEADBEEF held afterwards.
- Store burst, bus stalled: 4 STOREs to 0x0,0x4,0x8,0xC with data 1..4, busGnt=0 -> sbFull=1 after the 4th; 5th STORE dropped. Then busGnt=1 -> writes appear in order 0,1,2,3 with data 1..4; sbFull clears after the first pop.
- Load behind store to same word: STORE 0x55 to 0x20, then LOAD 0x20, busRdata echoes the written value:
  - Without forward: write issued before the read; dataToCpu=0x55.
  - With forward: no read issued; dataSent at cycle 1; dataToCpu=0x55.
- Grant backpressure: LOAD with busGnt low for 5 cycles -> busReq, busAddr, busWe stable for all 5 cycles; exactly one accepted read.
- Reset mid-load: assert rst_n=0 in LD_WAIT, release, then drive busRvalid=1 -> no dataSent, dataToCpu=0, busReq=0, sbFull=0.
- Wrap-around: 10 STOREs with random busGnt, SB_DEPTH=4 -> all 10 writes appear in order; no loss or duplication.
